// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : arb_pkg
// Brief  : Shared types and line-size constants for the refill read arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package arb_pkg;

   localparam int LINE_OFFSET_W_DEF = 5;
   localparam int LINE_WIDTH        = 8 << LINE_OFFSET_W_DEF;
   localparam int LINE_WORD_NUM     = LINE_WIDTH / 32;
   localparam int STARVE_CNT_W      = 4;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ADDR = 2'd1,
      ARB_DATA = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_DATA = 1'b0,
      OWN_INST = 1'b1
   } arb_owner_t;

   function automatic logic [STARVE_CNT_W-1:0] starve_max_val(input int max);
      return STARVE_CNT_W'(max);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : mem_rd_arbiter_if
// Brief  : One cache-line read-burst port; master issues requests, slave serves them.
// Rev    : 1.0  initial release
// ============================================================================
interface mem_rd_arbiter_if;

   logic        req;
   logic [2:0]  rd_type;
   logic [31:0] addr;
   logic        rdy;
   logic        ret_valid;
   logic        ret_last;
   logic [31:0] ret_data;

   modport master (
      output req, rd_type, addr,
      input  rdy, ret_valid, ret_last, ret_data
   );

   modport slave (
      input  req, rd_type, addr,
      output rdy, ret_valid, ret_last, ret_data
   );

endinterface
`default_nettype wire

// File: rtl/arb_prio_sel.sv
`default_nettype none
// ============================================================================
// Module : arb_prio_sel
// Brief  : Combinational grant select: data priority, write-buffer hazard hold,
//          inst anti-starvation override.
// Rev    : 1.0  initial release
// ============================================================================
module arb_prio_sel
   import arb_pkg::*;
#(
   parameter int LINE_OFFSET_W = 5,
   parameter int STARVE_MAX    = 4
) (
   input  logic                      en,
   input  logic                      inst_req,
   input  logic                      data_req,
   input  logic [31-LINE_OFFSET_W:0] data_line,
   input  logic                      wb_busy,
   input  logic [31-LINE_OFFSET_W:0] wb_line_addr,
   input  logic [STARVE_CNT_W-1:0]   starve_cnt,
   output logic                      grant_inst,
   output logic                      grant_data,
   output logic                      wb_hold
);

   logic line_hit;
   logic data_cand;
   logic inst_first;

   always_comb begin
      line_hit   = wb_busy && (data_line == wb_line_addr);
      data_cand  = data_req && !line_hit;
      inst_first = inst_req && (starve_cnt == starve_max_val(STARVE_MAX));
      grant_inst = en && inst_req && (inst_first || !data_cand);
      grant_data = en && data_cand && !inst_first;
      wb_hold    = en && data_req && line_hit;
   end

endmodule
`default_nettype wire

// File: rtl/mem_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_rd_arbiter
// Brief  : Shares one read-burst port between icache and dcache refills.
//          Optional macro ARB_PERF_CNT_EN adds grant / wb-hold perf counters.
// Rev    : 1.0  initial release
// ============================================================================
module mem_rd_arbiter
   import arb_pkg::*;
#(
   parameter int LINE_OFFSET_W = 5,
   parameter int STARVE_MAX    = 4
) (
   input  logic                      clk,
   input  logic                      resetn,
   mem_rd_arbiter_if.slave           inst_if,
   mem_rd_arbiter_if.slave           data_if,
   mem_rd_arbiter_if.master          mem_if,
   input  logic                      wb_busy,
   input  logic [31-LINE_OFFSET_W:0] wb_line_addr,
   output logic                      arb_err
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]               perf_inst_grants,
   output logic [31:0]               perf_data_grants,
   output logic [31:0]               perf_wb_hold_cyc
`endif
);

   arb_state_t                state_q, state_d;
   arb_owner_t                owner_q, owner_d;
   logic [2:0]                type_q, type_d;
   logic [31:0]               addr_q, addr_d;
   logic [STARVE_CNT_W-1:0]   starve_q, starve_d;
   logic                      err_q, err_d;

   logic in_idle, in_addr, inst_sel, data_sel;
   logic grant_inst, grant_data, wb_hold;

   assign in_idle = (state_q == ARB_IDLE);
   assign in_addr = (state_q == ARB_ADDR);

   arb_prio_sel #(
      .LINE_OFFSET_W (LINE_OFFSET_W),
      .STARVE_MAX    (STARVE_MAX)
   ) u_prio_sel (
      .en           (in_idle),
      .inst_req     (inst_if.req),
      .data_req     (data_if.req),
      .data_line    (data_if.addr[31:LINE_OFFSET_W]),
      .wb_busy      (wb_busy),
      .wb_line_addr (wb_line_addr),
      .starve_cnt   (starve_q),
      .grant_inst   (grant_inst),
      .grant_data   (grant_data),
      .wb_hold      (wb_hold)
   );

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      type_d   = type_q;
      addr_d   = addr_q;
      starve_d = starve_q;
      err_d    = err_q;

      if (mem_if.ret_valid && (state_q != ARB_DATA)) err_d = 1'b1;

      case (state_q)
         ARB_IDLE: begin
            if (grant_inst) begin
               owner_d = OWN_INST;
               type_d  = inst_if.rd_type;
               addr_d  = inst_if.addr;
               state_d = ARB_ADDR;
            end else if (grant_data) begin
               owner_d = OWN_DATA;
               type_d  = data_if.rd_type;
               addr_d  = data_if.addr;
               state_d = ARB_ADDR;
            end
         end
         ARB_ADDR: if (mem_if.rdy) state_d = ARB_DATA;
         ARB_DATA: if (mem_if.ret_valid && mem_if.ret_last) state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase

      // Counts consecutive data wins only while inst is actually waiting.
      if (!inst_if.req || grant_inst)
         starve_d = '0;
      else if (grant_data && (starve_q != starve_max_val(STARVE_MAX)))
         starve_d = starve_q + 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ARB_IDLE;
         owner_q  <= OWN_DATA;
         type_q   <= '0;
         addr_q   <= '0;
         starve_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         type_q   <= type_d;
         addr_q   <= addr_d;
         starve_q <= starve_d;
         err_q    <= err_d;
      end
   end

   assign inst_sel = (state_q == ARB_DATA) && (owner_q == OWN_INST);
   assign data_sel = (state_q == ARB_DATA) && (owner_q == OWN_DATA);

   assign inst_if.rdy       = grant_inst;
   assign inst_if.ret_valid = inst_sel && mem_if.ret_valid;
   assign inst_if.ret_last  = inst_sel && mem_if.ret_last;
   assign inst_if.ret_data  = inst_sel ? mem_if.ret_data : 32'd0;

   assign data_if.rdy       = grant_data;
   assign data_if.ret_valid = data_sel && mem_if.ret_valid;
   assign data_if.ret_last  = data_sel && mem_if.ret_last;
   assign data_if.ret_data  = data_sel ? mem_if.ret_data : 32'd0;

   // Latched request fields are only presented while the request is live.
   assign mem_if.req     = in_addr;
   assign mem_if.rd_type = in_addr ? type_q : 3'd0;
   assign mem_if.addr    = in_addr ? addr_q : 32'd0;

   assign arb_err = err_q;

`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_inst_q, perf_inst_d;
   logic [31:0] perf_data_q, perf_data_d;
   logic [31:0] perf_hold_q, perf_hold_d;

   always_comb begin
      perf_inst_d = perf_inst_q + {31'd0, grant_inst};
      perf_data_d = perf_data_q + {31'd0, grant_data};
      perf_hold_d = perf_hold_q + {31'd0, wb_hold};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         perf_inst_q <= '0;
         perf_data_q <= '0;
         perf_hold_q <= '0;
      end else begin
         perf_inst_q <= perf_inst_d;
         perf_data_q <= perf_data_d;
         perf_hold_q <= perf_hold_d;
      end
   end

   assign perf_inst_grants = perf_inst_q;
   assign perf_data_grants = perf_data_q;
   assign perf_wb_hold_cyc = perf_hold_q;
`else
   logic unused_wb_hold;
   assign unused_wb_hold = wb_hold;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_rd_arbiter
// Brief  : Directed self-checking bench for mem_rd_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_rd_arbiter;

   localparam int LINE_OFFSET_W = 5;
   localparam int STARVE_MAX    = 4;

   logic                      clk = 1'b0;
   logic                      resetn = 1'b0;
   logic                      wb_busy;
   logic [31-LINE_OFFSET_W:0] wb_line_addr;
   logic                      arb_err;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_inst_grants, perf_data_grants, perf_wb_hold_cyc;
`endif

   mem_rd_arbiter_if inst_bus ();
   mem_rd_arbiter_if data_bus ();
   mem_rd_arbiter_if mem_bus ();

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_rd_arbiter #(
      .LINE_OFFSET_W (LINE_OFFSET_W),
      .STARVE_MAX    (STARVE_MAX)
   ) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .inst_if      (inst_bus.slave),
      .data_if      (data_bus.slave),
      .mem_if       (mem_bus.master),
      .wb_busy      (wb_busy),
      .wb_line_addr (wb_line_addr),
      .arb_err      (arb_err)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_inst_grants (perf_inst_grants),
      .perf_data_grants (perf_data_grants),
      .perf_wb_hold_cyc (perf_wb_hold_cyc)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(output bit got_inst);
      bit ok;
      ok = 1'b0;
      got_inst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (inst_bus.rdy || data_bus.rdy) begin
            ok = 1'b1;
            got_inst = inst_bus.rdy;
            break;
         end
         tick();
      end
      if (!ok) chk("grant_timeout", 32'd0, 32'd1);
   endtask

   // Entered in the grant cycle; leaves one cycle after the last beat (back in IDLE).
   task automatic run_burst(input bit is_inst, input logic [2:0] exp_type,
                            input logic [31:0] exp_addr, input int beats, input bit drop_req);
      tick();
      if (drop_req) begin
         if (is_inst) inst_bus.req = 1'b0;
         else         data_bus.req = 1'b0;
      end
      chk("mem_req_addr_phase", 32'(mem_bus.req), 32'd1);
      chk("mem_addr", mem_bus.addr, exp_addr);
      chk("mem_type", 32'(mem_bus.rd_type), 32'(exp_type));
      mem_bus.rdy = 1'b1;
      tick();
      mem_bus.rdy = 1'b0;
      for (int b = 0; b < beats; b++) begin
         mem_bus.ret_valid = 1'b1;
         mem_bus.ret_last  = (b == beats - 1);
         mem_bus.ret_data  = 32'hD000_0000 + 32'(b);
         #1;
         chk("owner_valid", 32'(is_inst ? inst_bus.ret_valid : data_bus.ret_valid), 32'd1);
         chk("other_valid", 32'(is_inst ? data_bus.ret_valid : inst_bus.ret_valid), 32'd0);
         chk("owner_data", is_inst ? inst_bus.ret_data : data_bus.ret_data, 32'hD000_0000 + 32'(b));
         chk("owner_last", 32'(is_inst ? inst_bus.ret_last : data_bus.ret_last), 32'(b == beats - 1));
         tick();
      end
      mem_bus.ret_valid = 1'b0;
      mem_bus.ret_last  = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_req"},  32'(mem_bus.req), 32'd0);
      chk({tag, "_mem_addr"}, mem_bus.addr, 32'd0);
      chk({tag, "_mem_type"}, 32'(mem_bus.rd_type), 32'd0);
      chk({tag, "_rdy"},      32'({inst_bus.rdy, data_bus.rdy}), 32'd0);
      chk({tag, "_ret"},      32'({inst_bus.ret_valid, data_bus.ret_valid,
                                   inst_bus.ret_last, data_bus.ret_last}), 32'd0);
      chk({tag, "_ret_data"}, inst_bus.ret_data | data_bus.ret_data, 32'd0);
      chk({tag, "_arb_err"},  32'(arb_err), 32'd0);
`ifdef ARB_PERF_CNT_EN
      chk({tag, "_perf"}, perf_inst_grants | perf_data_grants | perf_wb_hold_cyc, 32'd0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit got;
      bit exp_order [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      inst_bus.req = 1'b0; inst_bus.rd_type = 3'd0; inst_bus.addr = 32'd0;
      data_bus.req = 1'b0; data_bus.rd_type = 3'd0; data_bus.addr = 32'd0;
      mem_bus.rdy = 1'b0; mem_bus.ret_valid = 1'b0; mem_bus.ret_last = 1'b0;
      mem_bus.ret_data = 32'd0;
      wb_busy = 1'b0; wb_line_addr = '0;

      #12;
      chk_all_zero("reset");
      @(negedge clk);
      resetn = 1'b1;
      tick();
      chk_all_zero("idle_no_req");

      // inst-only 8-beat refill
      inst_bus.req = 1'b1; inst_bus.rd_type = 3'b100; inst_bus.addr = 32'h1C00_0000;
      #1;
      chk("io_inst_rdy", 32'(inst_bus.rdy), 32'd1);
      chk("io_data_rdy", 32'(data_bus.rdy), 32'd0);
      run_burst(1'b1, 3'b100, 32'h1C00_0000, 8, 1'b1);
      chk("io_back_idle", 32'(mem_bus.req), 32'd0);
      chk("io_no_ret", 32'(inst_bus.ret_valid), 32'd0);
`ifdef ARB_PERF_CNT_EN
      chk("io_perf_inst", perf_inst_grants, 32'd1);
`endif

      // both held: data priority with anti-starvation
      inst_bus.req = 1'b1; inst_bus.rd_type = 3'b100; inst_bus.addr = 32'h1C00_0040;
      data_bus.req = 1'b1; data_bus.rd_type = 3'b100; data_bus.addr = 32'h0000_2000;
      for (int g = 0; g < 10; g++) begin
         wait_grant(got);
         chk($sformatf("starve_order_%0d", g), 32'(got), 32'(exp_order[g]));
         run_burst(got, 3'b100, got ? 32'h1C00_0040 : 32'h0000_2000, 1, 1'b0);
      end
      inst_bus.req = 1'b0;
      data_bus.req = 1'b0;
      tick();

      // write-buffer hazard holds the dcache read, not the icache one
      wb_busy = 1'b1; wb_line_addr = 27'h000_0800;
      data_bus.req = 1'b1; data_bus.rd_type = 3'b100; data_bus.addr = 32'h0001_0004;
      #1;
      chk("wb_hold_c0", 32'(data_bus.rdy), 32'd0);
      tick();
      chk("wb_hold_c1", 32'(data_bus.rdy), 32'd0);
      tick();
      inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0080;
      #1;
      chk("wb_inst_rdy", 32'(inst_bus.rdy), 32'd1);
      chk("wb_data_rdy", 32'(data_bus.rdy), 32'd0);
      run_burst(1'b1, 3'b100, 32'h1C00_0080, 2, 1'b1);
      #1;
      chk("wb_still_hold", 32'(data_bus.rdy), 32'd0);
      wb_busy = 1'b0;
      #1;
      chk("wb_release_rdy", 32'(data_bus.rdy), 32'd1);
      run_burst(1'b0, 3'b100, 32'h0001_0004, 2, 1'b1);
`ifdef ARB_PERF_CNT_EN
      chk("wb_perf_hold", perf_wb_hold_cyc, 32'd3);
      chk("wb_perf_inst", perf_inst_grants, 32'd4);
      chk("wb_perf_data", perf_data_grants, 32'd9);
`endif

      // downstream stall: request stays stable, no second accept
      data_bus.req = 1'b1; data_bus.rd_type = 3'b001; data_bus.addr = 32'h0000_2040;
      inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_00C0;
      #1;
      chk("stall_data_rdy", 32'(data_bus.rdy), 32'd1);
      tick();
      for (int c = 0; c < 10; c++) begin
         chk($sformatf("stall_req_%0d", c), 32'(mem_bus.req), 32'd1);
         chk($sformatf("stall_addr_%0d", c), mem_bus.addr, 32'h0000_2040);
         chk($sformatf("stall_type_%0d", c), 32'(mem_bus.rd_type), 32'd1);
         chk($sformatf("stall_rdy_%0d", c), 32'({inst_bus.rdy, data_bus.rdy}), 32'd0);
         tick();
      end
      data_bus.req = 1'b0;
      inst_bus.req = 1'b0;
      mem_bus.rdy = 1'b1;
      tick();
      mem_bus.rdy = 1'b0;
      mem_bus.ret_valid = 1'b1; mem_bus.ret_last = 1'b1; mem_bus.ret_data = 32'h1234_5678;
      #1;
      chk("stall_ret_valid", 32'(data_bus.ret_valid), 32'd1);
      chk("stall_ret_data", data_bus.ret_data, 32'h1234_5678);
      tick();
      mem_bus.ret_valid = 1'b0; mem_bus.ret_last = 1'b0;

      // stray return beat in IDLE
      chk("err_before", 32'(arb_err), 32'd0);
      mem_bus.ret_valid = 1'b1; mem_bus.ret_last = 1'b1; mem_bus.ret_data = 32'hBAD0_BAD0;
      #1;
      chk("err_no_ret", 32'({inst_bus.ret_valid, data_bus.ret_valid}), 32'd0);
      tick();
      mem_bus.ret_valid = 1'b0; mem_bus.ret_last = 1'b0;
      chk("err_set", 32'(arb_err), 32'd1);
      chk("err_stay_idle", 32'(mem_bus.req), 32'd0);
      tick(); tick(); tick();
      chk("err_sticky", 32'(arb_err), 32'd1);

      // asynchronous reset during DATA beat 3
      inst_bus.req = 1'b1; inst_bus.rd_type = 3'b100; inst_bus.addr = 32'h1C00_0100;
      #1;
      chk("rst_grant", 32'(inst_bus.rdy), 32'd1);
      tick();
      inst_bus.req = 1'b0;
      mem_bus.rdy = 1'b1;
      tick();
      mem_bus.rdy = 1'b0;
      for (int b = 0; b < 2; b++) begin
         mem_bus.ret_valid = 1'b1; mem_bus.ret_last = 1'b0; mem_bus.ret_data = 32'h0000_0010 + 32'(b);
         tick();
      end
      mem_bus.ret_data = 32'h0000_0012;
      #1;
      chk("rst_beat3_valid", 32'(inst_bus.ret_valid), 32'd1);
      resetn = 1'b0;
      #1;
      chk_all_zero("rst_async");
      mem_bus.ret_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      tick();
      data_bus.req = 1'b1; data_bus.rd_type = 3'b100; data_bus.addr = 32'h0000_3000;
      #1;
      chk("rst_fresh_rdy", 32'(data_bus.rdy), 32'd1);
      run_burst(1'b0, 3'b100, 32'h0000_3000, 4, 1'b1);
      chk("rst_final_err", 32'(arb_err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
